// File: rtl/ex_mul_unit_pkg.sv
// rtl/ex_mul_unit_pkg.sv - shared EX-stage constants: MUL FSM encodings, MUL decode and ALU control codes
package ex_mul_unit_pkg;

   typedef logic [1:0] mul_state_t;

   localparam logic [1:0] MUL_STATE_IDLE = 2'd0;
   localparam logic [1:0] MUL_STATE_RUN  = 2'd1;
   localparam logic [1:0] MUL_STATE_DONE = 2'd2;

   localparam logic [3:0] ALU_CTRL_ADD  = 4'd0;
   localparam logic [3:0] ALU_CTRL_SUB  = 4'd1;
   localparam logic [3:0] ALU_CTRL_AND  = 4'd2;
   localparam logic [3:0] ALU_CTRL_OR   = 4'd3;
   localparam logic [3:0] ALU_CTRL_XOR  = 4'd4;
   localparam logic [3:0] ALU_CTRL_SLL  = 4'd5;
   localparam logic [3:0] ALU_CTRL_SRL  = 4'd6;
   localparam logic [3:0] ALU_CTRL_SRA  = 4'd7;
   localparam logic [3:0] ALU_CTRL_SLT  = 4'd8;
   localparam logic [3:0] ALU_CTRL_MUL  = 4'd9;

   localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
   localparam logic [2:0] FUNCT3_MUL    = 3'b000;

   function automatic logic is_mul(input logic [6:0] funct7, input logic [2:0] funct3);
      return (funct7 == FUNCT7_MULDIV) && (funct3 == FUNCT3_MUL);
   endfunction

endpackage

// File: rtl/ex_mul_unit_mul_step.sv
// rtl/ex_mul_unit_mul_step.sv - one combinational shift-add step retiring BITS_PER_CYCLE multiplier bits
module mul_step
   import ex_mul_unit_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [XLEN-1:0] acc_i,
   input  logic [XLEN-1:0] mcand_i,
   input  logic [XLEN-1:0] mplier_i,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] mcand_o,
   output logic [XLEN-1:0] mplier_o
);

   // Partial products summed bit by bit, so no hard multiplier is inferred.
   always_comb begin
      acc_o = acc_i;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (mplier_i[i]) begin
            acc_o = acc_o + (mcand_i << i);
         end
      end
   end

   assign mcand_o  = mcand_i << BITS_PER_CYCLE;
   assign mplier_o = mplier_i >> BITS_PER_CYCLE;

endmodule

// File: rtl/ex_mul_unit.sv
// rtl/ex_mul_unit.sv - iterative shift-add MUL unit for the EX stage with pipeline stall request
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module ex_mul_unit
   import ex_mul_unit_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] data1_i,
   input  logic [XLEN-1:0] data2_i,
   output logic [XLEN-1:0] data_o,
   output logic            done_o,
   output logic            busy_o,
   output logic            stall_o
);

   localparam int STEPS = XLEN / BITS_PER_CYCLE;
   localparam int CW    = $clog2(STEPS) + 1;

   logic [1:0]      state_q,  state_d;
   logic [XLEN-1:0] acc_q,    acc_d;
   logic [XLEN-1:0] mcand_q,  mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;
   logic [XLEN-1:0] data_q,   data_d;
   logic [CW-1:0]   count_q,  count_d;

   logic [XLEN-1:0] acc_nx;
   logic [XLEN-1:0] mcand_nx;
   logic [XLEN-1:0] mplier_nx;
   logic            last_step;

   mul_step #(
      .XLEN           (XLEN),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .acc_i    (acc_q),
      .mcand_i  (mcand_q),
      .mplier_i (mplier_q),
      .acc_o    (acc_nx),
      .mcand_o  (mcand_nx),
      .mplier_o (mplier_nx)
   );

`ifdef MUL_EARLY_TERM_EN
   assign last_step = (count_q == CW'(STEPS - 1)) || (mplier_nx == '0);
`else
   assign last_step = (count_q == CW'(STEPS - 1));
`endif

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      data_d   = data_q;
      count_d  = count_q;
      case (state_q)
         MUL_STATE_IDLE: begin
            if (start_i && !flush_i) begin
               acc_d    = '0;
               mcand_d  = data1_i;
               mplier_d = data2_i;
               count_d  = '0;
               state_d  = MUL_STATE_RUN;
            end
         end
         MUL_STATE_RUN: begin
            if (flush_i) begin
               state_d = MUL_STATE_IDLE;
            end else begin
               acc_d    = acc_nx;
               mcand_d  = mcand_nx;
               mplier_d = mplier_nx;
               count_d  = count_q + CW'(1);
               if (last_step) begin
                  data_d  = acc_nx;
                  state_d = MUL_STATE_DONE;
               end
            end
         end
         // The result has retired; a late flush cannot take it back.
         MUL_STATE_DONE: state_d = MUL_STATE_IDLE;
         default:        state_d = MUL_STATE_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= MUL_STATE_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         data_q   <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         data_q   <= data_d;
         count_q  <= count_d;
      end
   end

   assign data_o  = data_q;
   assign done_o  = (state_q == MUL_STATE_DONE);
   assign busy_o  = (state_q == MUL_STATE_RUN);
   assign stall_o = start_i & ~done_o;

endmodule
